// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core MEM stage and an auxiliary requester.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default is fixed core priority.
module dmem_arbiter #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [DATA_W-1:0] core_rdata_o,
   input  logic              aux_req_i,
   input  logic              aux_we_i,
   input  logic [ADDR_W-1:0] aux_addr_i,
   input  logic [DATA_W-1:0] aux_wdata_i,
   output logic              aux_gnt_o,
   output logic              aux_rvalid_o,
   output logic [DATA_W-1:0] aux_rdata_o,
   output logic              stall_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic [ADDR_W-1:0] Address_o,
   output logic [DATA_W-1:0] Write_data_o,
   input  logic [DATA_W-1:0] Read_data_i
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;   // 1 = core, 0 = aux
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic                core_rvalid_q, core_rvalid_d;
   logic                aux_rvalid_q, aux_rvalid_d;
   logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;
   logic                core_gnt, aux_gnt;
   logic                core_wins;
   logic                capture;

   // Tie-break: decides which side takes the memory when both request.
`ifdef DMEM_ARB_RR_EN
   assign core_wins = core_req_i & (~aux_req_i | ~owner_q);
`else
   assign core_wins = core_req_i;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         cnt_q         <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         core_rvalid_q <= 1'b0;
         aux_rvalid_q  <= 1'b0;
         core_rdata_q  <= '0;
         aux_rdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         core_rvalid_q <= core_rvalid_d;
         aux_rvalid_q  <= aux_rvalid_d;
         core_rdata_q  <= core_rdata_d;
         aux_rdata_q   <= aux_rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      core_rvalid_d = 1'b0;
      aux_rvalid_d  = 1'b0;
      core_rdata_d  = core_rdata_q;
      aux_rdata_d   = aux_rdata_q;
      core_gnt      = 1'b0;
      aux_gnt       = 1'b0;
      capture       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A grant during reset would be lost, so none is offered then.
            if (!reset_i && (core_req_i || aux_req_i)) begin
               core_gnt    = core_wins;
               aux_gnt     = ~core_wins;
               owner_d     = core_wins;
               we_d        = core_wins ? core_we_i    : aux_we_i;
               addr_d      = core_wins ? core_addr_i  : aux_addr_i;
               wdata_d     = core_wins ? core_wdata_i : aux_wdata_i;
               mem_read_d  = core_wins ? ~core_we_i   : ~aux_we_i;
               mem_write_d = core_wins ? core_we_i    : aux_we_i;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (MEM_LAT <= 1) begin
               capture = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d   = CNT_W'(MEM_LAT - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               capture = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Completion is reported to the owner one cycle after the data is sampled.
      if (capture) begin
         if (owner_q) begin
            core_rvalid_d = 1'b1;
            core_rdata_d  = we_q ? '0 : Read_data_i;
         end else begin
            aux_rvalid_d  = 1'b1;
            aux_rdata_d   = we_q ? '0 : Read_data_i;
         end
      end
   end

   assign core_gnt_o    = core_gnt;
   assign aux_gnt_o     = aux_gnt;
   assign core_rvalid_o = core_rvalid_q;
   assign aux_rvalid_o  = aux_rvalid_q;
   assign core_rdata_o  = core_rdata_q;
   assign aux_rdata_o   = aux_rdata_q;
   assign MemRead_o     = mem_read_q;
   assign MemWrite_o    = mem_write_q;
   assign Address_o     = addr_q;
   assign Write_data_o  = wdata_q;
   assign stall_o       = (core_req_i & ~core_gnt) | (owner_q & (state_q != ST_IDLE));

endmodule
